// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for the 5-stage core.
// Shadows EX/MEM/WB destination metadata and drives the two EX operand-mux selects.
module fwd_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  logic            ex_valid_reg;
  logic [1:0][4:0] ex_rs_reg;
  logic [1:0]      ex_used_reg;
  logic [4:0]      ex_rd_reg;
  logic            ex_reg_write_reg;
  logic            ex_mem_read_reg;

  logic            mem_valid_reg;
  logic [4:0]      mem_rd_reg;
  logic            mem_reg_write_reg;
  logic            mem_mem_read_reg;

  logic            wb_valid_reg;
  logic [4:0]      wb_rd_reg;
  logic            wb_reg_write_reg;

  logic [CNT_W-1:0] stall_count_reg;

  logic [1:0][4:0] id_rs;
  logic [1:0]      id_used;
  logic [1:0]      id_dep;
  logic [1:0][1:0] fwd_sel;
  logic            bubble;

  assign id_rs   = {id_rs2, id_rs1};
  assign id_used = {id_rs2_used, id_rs1_used};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      logic use_ok;
      logic mem_hit;
      logic wb_hit;

      assign use_ok  = ex_valid_reg && ex_used_reg[gi];
      // A load still in MEM has no data yet, so it is never a forwarding source.
      assign mem_hit = use_ok && mem_valid_reg && mem_reg_write_reg && !mem_mem_read_reg &&
                       (mem_rd_reg != 5'd0) && (mem_rd_reg == ex_rs_reg[gi]);
      assign wb_hit  = use_ok && wb_valid_reg && wb_reg_write_reg &&
                       (wb_rd_reg != 5'd0) && (wb_rd_reg == ex_rs_reg[gi]);
      assign fwd_sel[gi] = mem_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00);

      assign id_dep[gi] = id_used[gi] && (id_rs[gi] == ex_rd_reg);
    end
  endgenerate

  // Flush squashes the dependent instruction, so it masks the load-use stall.
  assign stall = ex_valid_reg && ex_mem_read_reg && (ex_rd_reg != 5'd0) &&
                 (|id_dep) && !flush;
  assign bubble = stall || flush;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_valid_reg      <= 1'b0;
      ex_rs_reg         <= '0;
      ex_used_reg       <= '0;
      ex_rd_reg         <= '0;
      ex_reg_write_reg  <= 1'b0;
      ex_mem_read_reg   <= 1'b0;
      mem_valid_reg     <= 1'b0;
      mem_rd_reg        <= '0;
      mem_reg_write_reg <= 1'b0;
      mem_mem_read_reg  <= 1'b0;
      wb_valid_reg      <= 1'b0;
      wb_rd_reg         <= '0;
      wb_reg_write_reg  <= 1'b0;
      stall_count_reg   <= '0;
    end else begin
      wb_valid_reg      <= mem_valid_reg;
      wb_rd_reg         <= mem_rd_reg;
      wb_reg_write_reg  <= mem_reg_write_reg;

      mem_valid_reg     <= ex_valid_reg;
      mem_rd_reg        <= ex_rd_reg;
      mem_reg_write_reg <= ex_reg_write_reg;
      mem_mem_read_reg  <= ex_mem_read_reg;

      if (bubble) begin
        ex_valid_reg     <= 1'b0;
        ex_rs_reg        <= '0;
        ex_used_reg      <= '0;
        ex_rd_reg        <= '0;
        ex_reg_write_reg <= 1'b0;
        ex_mem_read_reg  <= 1'b0;
      end else begin
        ex_valid_reg     <= 1'b1;
        ex_rs_reg        <= id_rs;
        ex_used_reg      <= id_used;
        ex_rd_reg        <= id_rd;
        ex_reg_write_reg <= id_reg_write;
        ex_mem_read_reg  <= id_mem_read;
      end

      if (stall && (stall_count_reg != {CNT_W{1'b1}})) begin
        stall_count_reg <= stall_count_reg + CNT_W'(1);
      end
    end
  end

  assign fwd_a_sel   = fwd_sel[0];
  assign fwd_b_sel   = fwd_sel[1];
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: each step drives one ID instruction and
// queues the selects/stall/counter expected for that cycle.
module tb_fwd_hazard_ctrl;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct {
    string       tag;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        st;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_a_sel2, fwd_b_sel2;
  logic        stall, stall2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  int   errors = 0;
  int   checks = 0;
  int   nst    = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_count(stall_count)
  );

  fwd_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fwd_a_sel2), .fwd_b_sel(fwd_b_sel2), .stall(stall2), .stall_count(stall_count2)
  );

  function automatic instr_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic rw, input logic mr);
    instr_t i;
    i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2; i.rd = rd; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  task automatic chk(input string tag, input string what, input logic [15:0] obs,
                     input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s %s observed=%0h expected=%0h", tag, what, obs, expv);
    end
  endtask

  task automatic drive(input instr_t i, input logic fl);
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_rs1_used = i.u1; id_rs2_used = i.u2;
    id_rd = i.rd; id_reg_write = i.rw; id_mem_read = i.mr; flush = fl;
  endtask

  // One pipeline cycle: drive ID, expect outputs for this cycle, optionally reset at its edge.
  task automatic step(input string tag, input instr_t i, input logic fl, input logic [1:0] ea,
                      input logic [1:0] eb, input logic es, input logic rst);
    exp_t e;
    exp_t got;
    drive(i, fl);
    e.tag  = tag;
    e.a    = ea;
    e.b    = eb;
    e.st   = es;
    e.cnt  = (nst > 65535) ? 16'hffff : 16'(nst);
    e.cnt2 = (nst > 3) ? 2'd3 : 2'(nst);
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    chk(got.tag, "fwd_a_sel", {14'd0, fwd_a_sel}, {14'd0, got.a});
    chk(got.tag, "fwd_b_sel", {14'd0, fwd_b_sel}, {14'd0, got.b});
    chk(got.tag, "stall", {15'd0, stall}, {15'd0, got.st});
    chk(got.tag, "stall_count", stall_count, got.cnt);
    chk(got.tag, "stall_count_w2", {14'd0, stall_count2}, {14'd0, got.cnt2});
    $display("step %-10s a=%b b=%b stall=%b cnt=%0d cnt2=%0d", got.tag, fwd_a_sel, fwd_b_sel,
             stall, stall_count, stall_count2);
    if (rst) reset_n = 1'b0;
    @(posedge clk);
    #1;
    if (rst) begin
      reset_n = 1'b1;
      nst = 0;
    end else if (es) begin
      nst++;
    end
  endtask

  initial begin
    instr_t nop, add5, ld6, use6;
    nop  = mk(0, 0, 0, 0, 0, 0, 0);
    add5 = mk(1, 2, 1, 1, 5, 1, 0);
    ld6  = mk(1, 0, 1, 0, 6, 1, 1);
    use6 = mk(6, 1, 1, 1, 7, 1, 0);

    reset_n = 1'b0;
    drive(nop, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    step("reset",    nop,  0, 2'b00, 2'b00, 0, 0);
    step("raw_add",  add5, 0, 2'b00, 2'b00, 0, 0);
    step("raw_sub",  mk(5, 2, 1, 1, 7, 1, 0), 0, 2'b00, 2'b00, 0, 0);
    step("raw_a10",  nop,  0, 2'b10, 2'b00, 0, 0);
    step("swp_add",  add5, 0, 2'b00, 2'b00, 0, 0);
    step("swp_sub",  mk(2, 5, 1, 1, 7, 1, 0), 0, 2'b00, 2'b00, 0, 0);
    step("swp_b10",  nop,  0, 2'b00, 2'b10, 0, 0);
    step("d2_add",   add5, 0, 2'b00, 2'b00, 0, 0);
    step("d2_gap",   nop,  0, 2'b00, 2'b00, 0, 0);
    step("d2_or",    mk(5, 5, 1, 1, 8, 1, 0), 0, 2'b00, 2'b00, 0, 0);
    step("d2_01",    nop,  0, 2'b01, 2'b01, 0, 0);
    step("dbl_add1", add5, 0, 2'b00, 2'b00, 0, 0);
    step("dbl_add2", mk(3, 4, 1, 1, 5, 1, 0), 0, 2'b00, 2'b00, 0, 0);
    step("dbl_use",  mk(5, 6, 1, 1, 9, 1, 0), 0, 2'b00, 2'b00, 0, 0);
    step("dbl_10",   nop,  0, 2'b10, 2'b00, 0, 0);
    step("x0_prod",  mk(1, 0, 1, 0, 0, 1, 0), 0, 2'b00, 2'b00, 0, 0);
    step("st_x0",    mk(0, 0, 1, 1, 10, 0, 0), 0, 2'b00, 2'b00, 0, 0);
    step("x0_mem",   mk(10, 0, 1, 1, 11, 1, 0), 0, 2'b00, 2'b00, 0, 0);
    step("nw_wb",    nop,  0, 2'b00, 2'b00, 0, 0);
    step("lu_ld",    ld6,  0, 2'b00, 2'b00, 0, 0);
    step("lu_stall", use6, 0, 2'b00, 2'b00, 1, 0);
    step("lu_hold",  use6, 0, 2'b00, 2'b00, 0, 0);
    step("lu_01",    nop,  0, 2'b01, 2'b00, 0, 0);
    step("nd_ld",    ld6,  0, 2'b00, 2'b00, 0, 0);
    step("nd_add",   mk(1, 2, 1, 1, 7, 1, 0), 0, 2'b00, 2'b00, 0, 0);
    step("nd_after", nop,  0, 2'b00, 2'b00, 0, 0);
    step("fl_ld",    ld6,  0, 2'b00, 2'b00, 0, 0);
    step("fl_add",   use6, 1, 2'b00, 2'b00, 0, 0);
    step("fl_use7",  mk(7, 7, 1, 1, 9, 1, 0), 0, 2'b00, 2'b00, 0, 0);
    step("fl_bub",   nop,  0, 2'b00, 2'b00, 0, 0);
    step("rs_ld",    ld6,  0, 2'b00, 2'b00, 0, 0);
    step("rs_stall", mk(6, 6, 1, 1, 7, 1, 0), 0, 2'b00, 2'b00, 1, 1);
    step("rs_after", mk(6, 6, 1, 1, 7, 1, 0), 0, 2'b00, 2'b00, 0, 0);
    step("rs_next",  nop,  0, 2'b00, 2'b00, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step("sat_ld",    ld6,  0, 2'b00, 2'b00, 0, 0);
      step("sat_stall", use6, 0, 2'b00, 2'b00, 1, 0);
      step("sat_hold",  use6, 0, 2'b00, 2'b00, 0, 0);
      step("sat_fwd",   nop,  0, 2'b01, 2'b00, 0, 0);
    end
    step("sat_end",  nop,  0, 2'b00, 2'b00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Pipeline forwarding and load-use hazard controller for the 5-stage 64-bit core. It shadows the destination-register metadata of the instructions in EX, MEM and WB, and from that drives the select inputs of the two EX-stage 3:1 operand muxes. The select encoding is 00 = register file, 01 = WB result, 10 = EX/MEM ALU result. It also raises a one-cycle stall on a load-use dependency, accepts a branch flush, and counts stall cycles for performance monitoring.

## Interface
- CNT_W, 16, width of the stall-cycle counter
- clk  in  1  core clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  the ID instruction actually reads rs1 / rs2
- id_rd  in  5  destination register of the ID instruction
- id_reg_write  in  1  the ID instruction writes id_rd
- id_mem_read  in  1  the ID instruction is a load
- flush  in  1  branch taken: the instruction in ID is squashed
- fwd_a_sel, fwd_b_sel  out  2 each  operand-mux selects for the EX instruction's rs1 / rs2
- stall  out  1  hold PC and IF/ID, inject a bubble into ID/EX
- stall_count  out  CNT_W  saturating count of cycles with stall=1

## Operation
- Internal shadow stages track the pipeline:
  - EX: valid, rs1, rs2, rs1_used, rs2_used, rd, reg_write, mem_read
  - MEM: valid, rd, reg_write, mem_read
  - WB: valid, rd, reg_write
- Each edge with reset_n=1, the stages advance:
  - WB <= MEM
  - MEM <= EX
  - EX <= the ID capture, or a bubble (valid=0, all other fields 0) if stall=1 or flush=1.
- stall (combinational) asserts when all of the following hold:
  - the EX stage is valid, has mem_read=1 and rd≠0;
  - (id_rs1_used and id_rs1==EX.rd) or (id_rs2_used and id_rs2==EX.rd);
  - flush=0. flush overrides stall, because the dependent instruction is being squashed.
- Forwarding for operand A (B is identical using rs2 / rs2_used). Priority, highest first:
  - Case 1: EX.valid, EX.rs1_used, MEM.valid, MEM.reg_write, !MEM.mem_read, MEM.rd≠0, MEM.rd==EX.rs1 -> 10
  - Case 2: otherwise EX.valid, EX.rs1_used, WB.valid, WB.reg_write, WB.rd≠0, WB.rd==EX.rs1 -> 01
  - Case 3: otherwise -> 00
- Selects are never 11.
- A MEM-stage load never forwards 10. The load-use stall guarantees the consumer sees the load in WB, which gives 01.
- stall_count increments on every edge where stall=1 and saturates at 2^CNT_W-1; it does not wrap.
- Reset (synchronous, reset_n=0 at an edge):
  - all stage valids and fields cleared;
  - stall_count=0;
  - consequently fwd_a_sel=fwd_b_sel=00 and stall=0 from the following cycle.
  - Reset asserted mid-stall aborts the stall; no pending state survives.

## Timing
- fwd_*_sel are functions of registered shadow state only. They are valid at the start of each cycle and have no input-to-output path.
- stall is combinational from the ID inputs and EX state, in the same cycle. Its required path is to the PC/IF-ID enables before the next edge.
- Load-use stall lasts exactly 1 cycle. On the next cycle the load sits in MEM, EX holds a bubble, and stall deasserts (the EX bubble has mem_read=0).
- Forwarding latency: a producer issued in cycle N makes its dependent in EX see 10 at N+2 (adjacent) or 01 at N+3 (one instruction between).
- Simultaneous flush and stall: flush wins, stall=0, a bubble enters EX, and stall_count does not increment.
- Upstream must hold ID inputs stable while stall=1. The block re-evaluates them each cycle.

## Test plan
- Adjacent RAW: add x5 (rd=5, reg_write) then sub x7,x5,x2 -> fwd_a_sel=10, fwd_b_sel=00 when sub is in EX. With the operands swapped (x2,x5) -> fwd_b_sel=10.
- Distance-2 and double hazard:
  - add x5; nop; or x8,x5,x5 -> both selects 01.
  - add x5; add x5; use x5 -> 10, because the MEM stage has priority.
- x0 and non-writers: rd=0 with reg_write=1, or a matching rd with reg_write=0 (store/branch) -> selects stay 00.
- Load-use: ld x6 then add x7,x6,x1 -> stall=1 for exactly one cycle and stall_count goes 0->1, then fwd_a_sel=01 when add is in EX. ld x6 then add x7,x1,x2 -> no stall.
- Flush priority: load-use condition with flush=1 in the same cycle -> stall=0, an EX bubble, next-cycle selects 00, stall_count unchanged.
- Reset mid-operation: reset_n=0 for one edge while stall=1 and the stages are full -> next cycle stall=0, selects 00, stall_count=0. With CNT_W=2, four consecutive stalls leave the counter at 3 (saturated).
